// File: rtl/apb_rgb_pixel_packer.sv
// apb_rgb_pixel_packer
//   APB slave that collects single colour bytes (R, then G, then B) and packs
//   each completed triple into a 24-bit pixel.  Packed pixels go into a
//   first-word-fall-through FIFO that feeds a downstream grayscale core with
//   a valid/ready handshake.
//
// Ports
//   PCLK, PRESETn      clock (rising edge), asynchronous active-low reset
//   PADDR..PSTRB       APB requester inputs (PPROT is accepted but ignored)
//   PREADY             combinational; stalls only a B write into a full FIFO
//   PSLVERR            data write with PSTRB[0]=0
//   PRDATA             {16'h0, fifo_count[7:0], 6'h0, phase[1:0]} on reads
//   pix_valid/pix_data FIFO head, {R,G,B}
//   pix_ready          downstream accept; pops the head when pix_valid=1
//   pix_count          pixels pushed since reset or the last flush
module apb_rgb_pixel_packer #(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            STRB_WIDTH = 4,
  parameter int unsigned            FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0]  CTRL_ADDR  = 32'hFFFF_FFF0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [2:0]            PPROT,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  pix_valid,
  output logic [23:0]           pix_data,
  input  logic                  pix_ready,
  output logic [31:0]           pix_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  phase_e          phase, phase_nxt;
  logic [7:0]      r_q, g_q, b_q;
  logic [23:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic access, is_ctrl, data_wr, full, done;
  logic wr_ok, flush, rd_done;
  logic ld_r, ld_g, push, pop;
  logic [31:0] rd_word;
  logic unused_ok;

  assign unused_ok = ^{PPROT, PWDATA[DATA_WIDTH-1:8], PSTRB[STRB_WIDTH-1:1]};

  assign access  = PSEL & PENABLE;
  assign is_ctrl = (PADDR == CTRL_ADDR);
  assign data_wr = access & PWRITE & ~is_ctrl;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));

  // The only wait state: a B-byte write that would push into a full FIFO.
  // A pop in the same cycle does not release it; the write completes the
  // cycle after space appears.
  assign PREADY  = access & ~(data_wr & (phase == PH_B) & full);
  assign done    = access & PREADY;

  assign wr_ok   = done & data_wr & PSTRB[0];
  assign PSLVERR = done & data_wr & ~PSTRB[0];
  assign flush   = done & PWRITE & is_ctrl & PWDATA[0];
  assign rd_done = done & ~PWRITE;

  assign pix_valid = (count != '0);
  assign pix_data  = mem[rd_ptr];
  assign pop       = pix_valid & pix_ready;

  assign rd_word = {16'h0, 8'(count), 6'h0, phase};
  assign PRDATA  = rd_done ? DATA_WIDTH'(rd_word) : '0;

  // Byte-phase FSM: state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) phase <= PH_R;
    else          phase <= phase_nxt;
  end

  // Byte-phase FSM: next state
  always_comb begin
    phase_nxt = phase;
    if (flush) begin
      phase_nxt = PH_R;
    end else if (wr_ok) begin
      unique case (phase)
        PH_R:    phase_nxt = PH_G;
        PH_G:    phase_nxt = PH_B;
        default: phase_nxt = PH_R;
      endcase
    end
  end

  // Byte-phase FSM: outputs
  always_comb begin
    ld_r = 1'b0;
    ld_g = 1'b0;
    push = 1'b0;
    unique case (phase)
      PH_R:    ld_r = wr_ok;
      PH_G:    ld_g = wr_ok;
      default: push = wr_ok;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      if (ld_r) r_q <= PWDATA[7:0];
      if (ld_g) g_q <= PWDATA[7:0];
      if (push) b_q <= PWDATA[7:0];
    end
  end

  // FIFO storage; entries are cleared on reset so pix_data reads 0 out of reset
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= {r_q, g_q, PWDATA[7:0]};
    end
  end

  // Pointers, occupancy and pixel counter; a flush overrides any push/pop
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pix_count <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pix_count <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        pix_count <= pix_count + 32'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rgb_pixel_packer.sv
module tb_apb_rgb_pixel_packer;

  localparam logic [31:0] CTRL = 32'hFFFF_FFF0;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic [2:0]  PPROT;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic [31:0] pix_count;

  int total = 0;
  int bad   = 0;

  logic        err;
  logic [31:0] rd;
  logic [23:0] exp_px [5];

  apb_rgb_pixel_packer #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .STRB_WIDTH(4),
    .FIFO_DEPTH(4),
    .CTRL_ADDR (CTRL)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .PADDR    (PADDR),
    .PPROT    (PPROT),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .PRDATA   (PRDATA),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .pix_ready(pix_ready),
    .pix_count(pix_count)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic e);
    logic done;
    int   n;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d; PSTRB = s;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    done = 1'b0; e = 1'b0; n = 0;
    while (!done && n < 50) begin
      @(negedge PCLK);
      if (PREADY) begin done = 1'b1; e = PSLVERR; end
      n++;
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    chk("wr_done", {31'b0, done}, 32'd1);
  endtask

  task automatic apb_rd(output logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0;
    @(negedge PCLK);
    chk("rd_setup_prdata", PRDATA, 32'h0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("rd_pready", {31'b0, PREADY}, 32'd1);
    d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    exp_px[0] = 24'hA0A1A2;
    exp_px[1] = 24'hA3A4A5;
    exp_px[2] = 24'hA6A7A8;
    exp_px[3] = 24'hA9AAAB;
    exp_px[4] = 24'hACADAE;

    PRESETn = 1'b0; PADDR = '0; PPROT = '0; PSEL = 1'b0; PENABLE = 1'b0;
    PWRITE = 1'b0; PWDATA = '0; PSTRB = '0; pix_ready = 1'b1;

    // reset state
    @(posedge PCLK); #1;
    chk("rst_pix_valid", {31'b0, pix_valid}, 32'd0);
    chk("rst_pix_data",  {8'b0, pix_data},   32'd0);
    chk("rst_pix_count", pix_count,          32'd0);
    chk("rst_pready",    {31'b0, PREADY},    32'd0);
    chk("rst_prdata",    PRDATA,             32'd0);
    @(negedge PCLK); PRESETn = 1'b1;

    // single pixel with downstream always ready: one-cycle valid pulse
    apb_wr(32'h0, 32'h11, 4'hF, err);
    apb_wr(32'h4, 32'h22, 4'h1, err);
    apb_wr(32'h8, 32'h33, 4'h1, err);
    chk("p1_err",   {31'b0, err},       32'd0);
    chk("p1_valid", {31'b0, pix_valid}, 32'd1);
    chk("p1_data",  {8'b0, pix_data},   32'h112233);
    chk("p1_count", pix_count,          32'd1);
    @(posedge PCLK); #1;
    chk("p1_valid_drop", {31'b0, pix_valid}, 32'd0);
    @(negedge PCLK);
    chk("idle_prdata", PRDATA, 32'd0);

    // back-pressure: fill the FIFO, stall the 15th byte, release one slot
    apb_wr(CTRL, 32'h1, 4'h1, err);
    chk("flush_count", pix_count, 32'd0);
    pix_ready = 1'b0;
    for (int i = 0; i < 14; i++) apb_wr(32'h0, 32'hA0 + i, 4'h1, err);
    apb_rd(rd);
    chk("full_status", rd, 32'h0000_0402);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hAE; PSTRB = 4'h1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("full_stall", {31'b0, PREADY}, 32'd0);
    end
    @(posedge PCLK); #1;
    pix_ready = 1'b1;
    @(negedge PCLK);
    chk("pop_cycle_stall", {31'b0, PREADY}, 32'd0);
    chk("head_p0", {8'b0, pix_data}, {8'b0, exp_px[0]});
    @(posedge PCLK); #1;
    pix_ready = 1'b0;
    @(negedge PCLK);
    chk("stall_release", {31'b0, PREADY}, 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    chk("bp_count", pix_count, 32'd5);
    pix_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      @(negedge PCLK);
      chk("drain_valid", {31'b0, pix_valid}, 32'd1);
      chk("drain_data",  {8'b0, pix_data},   {8'b0, exp_px[k]});
      @(posedge PCLK);
    end
    #1;
    chk("drained", {31'b0, pix_valid}, 32'd0);
    pix_ready = 1'b0;

    // missing byte strobe: error response, no state change
    apb_wr(32'h0, 32'h44, 4'h0, err);
    chk("strb0_err", {31'b0, err}, 32'd1);
    apb_rd(rd);
    chk("strb0_status", rd, 32'h0);

    // partial pixel, ignored control write, flush, then a clean pixel
    apb_wr(32'h0, 32'h55, 4'h1, err);
    apb_wr(32'h0, 32'h66, 4'h1, err);
    apb_wr(CTRL, 32'h0, 4'h1, err);
    apb_rd(rd);
    chk("ctrl0_status", rd, 32'h0000_0002);
    apb_wr(CTRL, 32'h1, 4'h1, err);
    apb_rd(rd);
    chk("flush_status", rd, 32'h0);
    apb_wr(32'h0, 32'hAA, 4'h1, err);
    apb_wr(32'h0, 32'hBB, 4'h1, err);
    apb_wr(32'h0, 32'hCC, 4'h1, err);
    chk("fl_data",  {8'b0, pix_data}, 32'hAABBCC);
    chk("fl_count", pix_count,        32'd1);

    // flush coinciding with pops leaves the FIFO empty
    for (int i = 0; i < 9; i++) apb_wr(32'h0, 32'h10 + i, 4'h1, err);
    apb_rd(rd);
    chk("four_full", rd, 32'h0000_0400);
    pix_ready = 1'b1;
    apb_wr(CTRL, 32'h1, 4'h1, err);
    pix_ready = 1'b0;
    chk("flushpop_valid", {31'b0, pix_valid}, 32'd0);
    chk("flushpop_count", pix_count,          32'd0);

    // reset in the middle of a pixel discards the partial bytes
    apb_wr(32'h0, 32'hAA, 4'h1, err);
    apb_wr(32'h0, 32'hBB, 4'h1, err);
    apb_wr(32'h0, 32'hCC, 4'h1, err);
    apb_wr(32'h0, 32'h77, 4'h1, err);
    apb_wr(32'h0, 32'h88, 4'h1, err);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_valid", {31'b0, pix_valid}, 32'd0);
    chk("async_data",  {8'b0, pix_data},   32'd0);
    chk("async_count", pix_count,          32'd0);
    @(negedge PCLK); PRESETn = 1'b1;
    apb_wr(32'h0, 32'h01, 4'h1, err);
    apb_wr(32'h0, 32'h02, 4'h1, err);
    apb_wr(32'h0, 32'h03, 4'h1, err);
    chk("rst_px_data",  {8'b0, pix_data}, 32'h010203);
    chk("rst_px_count", pix_count,        32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
